// File: rtl/stim_pkg.sv
// Shared types and constants for the TMS stimulation pulse sequencer.
package stim_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE     = 2'd0,
        MODE_REPETITIVE = 2'd1,
        MODE_TBS        = 2'd2,
        MODE_RESERVED   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRE,
        ST_DEAD,
        ST_RECOV,
        ST_GAP,
        ST_BGAP,
        ST_DONE
    } state_e;

    localparam int DEAD_US_DEFAULT = 4;

    localparam int ON_W     = 12;
    localparam int PERIOD_W = 24;
    localparam int PPB_W    = 4;
    localparam int TRAIN_W  = 16;

    // Widths wide enough that the validation sums and products cannot overflow.
    localparam int PULSE_CMP_W = PERIOD_W + 1;
    localparam int BURST_CMP_W = PERIOD_W + PPB_W;

    typedef struct packed {
        mode_e               mode;
        logic [ON_W-1:0]     igbt_on;
        logic [ON_W-1:0]     scr_on;
        logic [PERIOD_W-1:0] period;
        logic [PPB_W-1:0]    ppb;
        logic [PERIOD_W-1:0] burst;
        logic [TRAIN_W-1:0]  train;
    } run_cfg_t;

endpackage

// File: rtl/us_tick_gen.sv
// Divides the system clock down to a 1-cycle strobe once per microsecond.
module us_tick_gen #(
    parameter int TICK_DIV = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // NOTE: registers are updated with non-blocking assignments only, so all flops sample together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/stim_sequencer.sv
// IGBT discharge / SCR recovery pulse sequencer for single, rTMS and theta-burst runs.
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int TICK_DIV = 50,
    parameter int NUM_IGBT = 5,
    parameter int NUM_SCR  = 2,
    parameter int DEAD_US  = DEAD_US_DEFAULT
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          mode,
    input  logic [NUM_IGBT-1:0] igbt_mask,
    input  logic                scr_sel,
    input  logic [ON_W-1:0]     igbt_on_us,
    input  logic [ON_W-1:0]     scr_on_us,
    input  logic [PERIOD_W-1:0] pulse_period_us,
    input  logic [PPB_W-1:0]    pulses_per_burst,
    input  logic [PERIOD_W-1:0] burst_period_us,
    input  logic [TRAIN_W-1:0]  train_count,
    output logic [NUM_IGBT-1:0] igbt,
    output logic [NUM_SCR-1:0]  scr,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic [15:0]         pulse_cnt
);

    localparam logic [NUM_SCR-1:0] SCR_ONE = NUM_SCR'(1);

    state_e                state_q;
    run_cfg_t              cfg_q;
    logic [NUM_IGBT-1:0]   mask_q;
    logic                  scr_sel_q;
    logic [NUM_IGBT-1:0]   igbt_q;
    logic [NUM_SCR-1:0]    scr_q;
    logic                  busy_q, done_q, cfg_err_q;
    logic [15:0]           pulse_cnt_q;
    logic [ON_W-1:0]       st_q;
    logic [PERIOD_W-1:0]   per_q, bur_q;
    logic [PPB_W-1:0]      pib_q;
    logic [TRAIN_W-1:0]    bursts_q;

    logic tick, tick_clr, start_ok, accept;
    logic [PULSE_CMP_W-1:0] pulse_need;
    logic [BURST_CMP_W-1:0] burst_need;

    us_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_comb begin
        pulse_need = PULSE_CMP_W'(igbt_on_us) + PULSE_CMP_W'(DEAD_US) + PULSE_CMP_W'(scr_on_us);
        burst_need = BURST_CMP_W'(pulses_per_burst) * BURST_CMP_W'(pulse_period_us);
        start_ok   = 1'b1;
        if (igbt_mask == '0 || igbt_on_us == '0 || scr_on_us == '0) start_ok = 1'b0;
        if (mode_e'(mode) == MODE_RESERVED) start_ok = 1'b0;
        if (mode_e'(mode) != MODE_SINGLE && train_count == '0) start_ok = 1'b0;
        if (PULSE_CMP_W'(pulse_period_us) < pulse_need) start_ok = 1'b0;
        if (mode_e'(mode) == MODE_TBS &&
            (pulses_per_burst == '0 || BURST_CMP_W'(burst_period_us) < burst_need)) start_ok = 1'b0;
    end

    assign accept   = (state_q == ST_IDLE) && start && !abort && start_ok;
    assign tick_clr = accept;

    logic [ON_W-1:0] state_lim;
    logic st_done, period_hit, burst_hit, burst_last, run_last, new_burst, pulse_end, is_tbs;
    state_e after_state;

    always_comb begin
        unique case (state_q)
            ST_DEAD:  state_lim = ON_W'(DEAD_US);
            ST_RECOV: state_lim = cfg_q.scr_on;
            default:  state_lim = cfg_q.igbt_on;
        endcase
        st_done    = tick && (st_q == state_lim - 1'b1);
        period_hit = (per_q + 24'd1 == cfg_q.period);
        burst_hit  = (bur_q + 24'd1 == cfg_q.burst);
        is_tbs     = (cfg_q.mode == MODE_TBS);
        burst_last = (pib_q == cfg_q.ppb);
        new_burst  = !is_tbs || burst_last;
        unique case (cfg_q.mode)
            MODE_SINGLE:     run_last = 1'b1;
            MODE_REPETITIVE: run_last = (pulse_cnt_q == cfg_q.train);
            default:         run_last = burst_last && (bursts_q + 16'd1 == cfg_q.train);
        endcase
        // A pulse ends when its period expires, either in GAP or directly out of RECOV.
        pulse_end = tick && period_hit &&
                    (state_q == ST_GAP || (state_q == ST_RECOV && st_done));
        if (run_last)                            after_state = ST_DONE;
        else if (is_tbs && burst_last && !burst_hit) after_state = ST_BGAP;
        else                                     after_state = ST_FIRE;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            mask_q      <= '0;
            scr_sel_q   <= 1'b0;
            igbt_q      <= '0;
            scr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            pulse_cnt_q <= '0;
            st_q        <= '0;
            per_q       <= '0;
            bur_q       <= '0;
            pib_q       <= '0;
            bursts_q    <= '0;
        end else begin
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
            if (tick && state_q != ST_IDLE) begin
                st_q  <= st_q + 12'd1;
                per_q <= per_q + 24'd1;
                bur_q <= bur_q + 24'd1;
            end
            if (state_q != ST_IDLE && abort) begin
                state_q <= ST_IDLE;
                igbt_q  <= '0;
                scr_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: if (start && !abort) begin
                        if (start_ok) begin
                            cfg_q <= '{mode: mode_e'(mode), igbt_on: igbt_on_us,
                                       scr_on: scr_on_us, period: pulse_period_us,
                                       ppb: pulses_per_burst, burst: burst_period_us,
                                       train: train_count};
                            mask_q      <= igbt_mask;
                            scr_sel_q   <= scr_sel;
                            igbt_q      <= igbt_mask;
                            busy_q      <= 1'b1;
                            state_q     <= ST_FIRE;
                            st_q        <= '0;
                            per_q       <= '0;
                            bur_q       <= '0;
                            pib_q       <= '0;
                            bursts_q    <= '0;
                            pulse_cnt_q <= '0;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                    ST_FIRE: if (st_done) begin
                        igbt_q  <= '0;
                        st_q    <= '0;
                        state_q <= ST_DEAD;
                    end
                    ST_DEAD: if (st_done) begin
                        scr_q       <= SCR_ONE << scr_sel_q;
                        st_q        <= '0;
                        pulse_cnt_q <= pulse_cnt_q + 16'd1;
                        pib_q       <= pib_q + 4'd1;
                        state_q     <= ST_RECOV;
                    end
                    ST_RECOV: if (st_done) begin
                        scr_q <= '0;
                        st_q  <= '0;
                        if (!period_hit) state_q <= ST_GAP;
                    end
                    ST_GAP: ;
                    ST_BGAP: if (tick && burst_hit) begin
                        igbt_q  <= mask_q;
                        st_q    <= '0;
                        per_q   <= '0;
                        bur_q   <= '0;
                        state_q <= ST_FIRE;
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase

                if (pulse_end) begin
                    state_q <= after_state;
                    if (is_tbs && burst_last && !run_last) begin
                        pib_q    <= '0;
                        bursts_q <= bursts_q + 16'd1;
                    end
                    if (after_state == ST_DONE) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else if (after_state == ST_FIRE) begin
                        igbt_q <= mask_q;
                        st_q   <= '0;
                        per_q  <= '0;
                        if (new_burst) bur_q <= '0;
                    end
                end
            end
        end
    end

    // Abort kills the gates combinationally, ahead of the registered FSM.
    assign igbt      = abort ? '0 : igbt_q;
    assign scr       = abort ? '0 : scr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer at TICK_DIV=4 with hand-computed clock counts.
module tb_stim_sequencer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst, start, abort, scr_sel;
    logic [1:0]  mode;
    logic [4:0]  mask;
    logic [11:0] igbt_on, scr_on;
    logic [23:0] period, burst;
    logic [3:0]  ppb;
    logic [15:0] train;
    logic [4:0]  igbt;
    logic [1:0]  scr;
    logic        busy, done, cfg_err;
    logic [15:0] pulse_cnt;

    int errors = 0;
    int checks = 0;

    stim_sequencer #(.TICK_DIV(TD)) dut (
        .sys_clk(clk), .sys_rst(rst), .start(start), .abort(abort), .mode(mode),
        .igbt_mask(mask), .scr_sel(scr_sel), .igbt_on_us(igbt_on), .scr_on_us(scr_on),
        .pulse_period_us(period), .pulses_per_burst(ppb), .burst_period_us(burst),
        .train_count(train), .igbt(igbt), .scr(scr), .busy(busy), .done(done),
        .cfg_err(cfg_err), .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Gate invariant and start-while-busy must hold on every cycle.
    logic start_busy_seen = 1'b0;
    always @(negedge clk) begin
        if (!rst && (((|igbt) && (|scr)) || !$onehot0(scr)))
            check("gate_invariant", 32'({igbt, scr}), 0);
        if (start_busy_seen) check("start_while_busy_cfg_err", 32'(cfg_err), 0);
        start_busy_seen = start && busy;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic setcfg(input logic [1:0] m, input logic [4:0] mk, input logic sel,
                          input int on, input int son, input int per,
                          input int pp, input int bur, input int tr);
        mode = m; mask = mk; scr_sel = sel;
        igbt_on = 12'(on); scr_on = 12'(son); period = 24'(per);
        ppb = 4'(pp); burst = 24'(bur); train = 16'(tr);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    int rise_t[16];
    int nrise, igbt_len, igbt_fall, scr_rise, scr_len, done_at, cnt_at_done;
    int busy_low, mask_bad, scr_bad, cfg_seen;

    // Sample index 0 is the first sample after the accepting clock edge.
    task automatic watch(input int max_cyc, input int poke_at,
                         input logic [4:0] exp_mask, input logic [1:0] exp_scr);
        logic [4:0] prev_igbt;
        logic [1:0] prev_scr;
        prev_igbt = '0; prev_scr = '0;
        nrise = 0; igbt_len = 0; igbt_fall = -1; scr_rise = -1; scr_len = 0;
        done_at = -1; cnt_at_done = -1; busy_low = 0; mask_bad = 0; scr_bad = 0; cfg_seen = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if ((|igbt) && !(|prev_igbt) && nrise < 16) begin
                rise_t[nrise] = c;
                nrise++;
            end
            if ((|igbt) && igbt != exp_mask) mask_bad++;
            if ((|scr) && scr != exp_scr) scr_bad++;
            if (nrise == 1) begin
                if (|igbt) igbt_len++;
                if (!(|igbt) && (|prev_igbt)) igbt_fall = c;
                if ((|scr) && !(|prev_scr)) scr_rise = c;
                if (|scr) scr_len++;
            end
            if (cfg_err) cfg_seen++;
            if (done) begin
                done_at = c;
                cnt_at_done = int'(pulse_cnt);
                break;
            end
            if (!busy) busy_low++;
            prev_igbt = igbt;
            prev_scr  = scr;
            if (c == poke_at) begin
                start = 1'b1; mask = 5'b11111; period = 24'd9999; mode = 2'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic expect_reject(input string tag);
        do_start();
        check({tag, "_cfg_err"}, 32'(cfg_err), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_igbt"}, 32'(igbt), 0);
        @(posedge clk); #1;
        check({tag, "_cfg_err_clr"}, 32'(cfg_err), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    task automatic after_done(input string tag);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        @(posedge clk); #1;
        check({tag, "_done_strobe"}, 32'(done), 0);
        check({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        setcfg(2'd0, 5'b00011, 1'b1, 100, 20, 124, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_igbt", 32'(igbt), 0);
        check("rst_scr", 32'(scr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        check("rst_pulse_cnt", 32'(pulse_cnt), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // SINGLE with period exactly igbt_on+dead+scr_on: no GAP cycles.
        do_start();
        watch(3000, -1, 5'b00011, 2'b10);
        check("t1_nrise", nrise, 1);
        check("t1_rise0", rise_t[0], 0);
        check("t1_igbt_len", igbt_len, 100 * TD);
        check("t1_dead_len", scr_rise - igbt_fall, 4 * TD);
        check("t1_scr_len", scr_len, 20 * TD);
        check("t1_done_at", done_at, 124 * TD);
        check("t1_pulse_cnt", cnt_at_done, 1);
        check("t1_busy_low", busy_low, 0);
        check("t1_mask_bad", mask_bad, 0);
        check("t1_scr_bad", scr_bad, 0);
        after_done("t1");

        // REPETITIVE, with a start and input changes while busy.
        setcfg(2'd1, 5'b10101, 1'b1, 10, 5, 50, 0, 0, 3);
        do_start();
        watch(3000, 100, 5'b10101, 2'b10);
        check("t2_nrise", nrise, 3);
        check("t2_rise1", rise_t[1], 50 * TD);
        check("t2_rise2", rise_t[2], 100 * TD);
        check("t2_done_at", done_at, 150 * TD);
        check("t2_pulse_cnt", cnt_at_done, 3);
        check("t2_busy_low", busy_low, 0);
        check("t2_cfg_seen", cfg_seen, 0);
        check("t2_mask_bad", mask_bad, 0);
        after_done("t2");

        // TBS with a real inter-burst gap.
        setcfg(2'd2, 5'b11100, 1'b0, 10, 5, 30, 3, 150, 2);
        do_start();
        watch(5000, -1, 5'b11100, 2'b01);
        check("t3_nrise", nrise, 6);
        check("t3_rise2", rise_t[2], 60 * TD);
        check("t3_rise3", rise_t[3], 150 * TD);
        check("t3_rise5", rise_t[5], 210 * TD);
        check("t3_done_at", done_at, 240 * TD);
        check("t3_pulse_cnt", cnt_at_done, 6);
        check("t3_scr_bad", scr_bad, 0);
        after_done("t3");

        // TBS with burst period exactly ppb*period: no BGAP cycles.
        setcfg(2'd2, 5'b11100, 1'b0, 10, 5, 30, 3, 90, 2);
        do_start();
        watch(5000, -1, 5'b11100, 2'b01);
        check("t3b_nrise", nrise, 6);
        check("t3b_rise3", rise_t[3], 90 * TD);
        check("t3b_rise5", rise_t[5], 150 * TD);
        check("t3b_done_at", done_at, 180 * TD);
        after_done("t3b");

        setcfg(2'd1, 5'b00011, 1'b1, 100, 20, 100, 0, 0, 3);
        expect_reject("t4_period");
        setcfg(2'd3, 5'b00011, 1'b1, 10, 5, 50, 0, 0, 3);
        expect_reject("t4_mode3");
        setcfg(2'd1, 5'b00000, 1'b1, 10, 5, 50, 0, 0, 3);
        expect_reject("t4_mask0");
        setcfg(2'd2, 5'b00011, 1'b0, 10, 5, 30, 3, 89, 2);
        expect_reject("t4_burst");
        setcfg(2'd1, 5'b00011, 1'b1, 10, 5, 50, 0, 0, 0);
        expect_reject("t4_train0");

        // Abort and start together in IDLE: start dropped, no cfg_err.
        setcfg(2'd1, 5'b00011, 1'b1, 10, 5, 50, 0, 0, 3);
        abort = 1'b1;
        do_start();
        check("t4_abort_start_busy", 32'(busy), 0);
        check("t4_abort_start_cfg_err", 32'(cfg_err), 0);
        abort = 1'b0;
        @(posedge clk); #1;

        // Abort mid-FIRE of pulse 2, then a clean restart.
        do_start();
        repeat (50 * TD + 20) @(posedge clk);
        #1;
        check("t5_igbt_pre_abort", 32'(igbt), 32'(5'b00011));
        abort = 1'b1;
        #1;
        check("t5_igbt_abort_comb", 32'(igbt), 0);
        @(posedge clk); #1;
        check("t5_busy_after_abort", 32'(busy), 0);
        check("t5_igbt_after_abort", 32'(igbt), 0);
        abort = 1'b0;
        watch(300, -1, 5'b00011, 2'b10);
        check("t5_no_done", done_at, -1);
        check("t5_no_pulse", nrise, 0);
        do_start();
        watch(3000, -1, 5'b00011, 2'b10);
        check("t5_restart_nrise", nrise, 3);
        check("t5_restart_done_at", done_at, 150 * TD);
        after_done("t5");

        // Async reset during RECOV drops scr between clock edges.
        setcfg(2'd0, 5'b00011, 1'b1, 100, 20, 124, 0, 0, 0);
        do_start();
        repeat (430) @(posedge clk);
        #1;
        check("t6_scr_recov", 32'(scr), 32'(2'b10));
        #2 rst = 1'b1;
        #1;
        check("t6_scr_async", 32'(scr), 0);
        check("t6_busy_async", 32'(busy), 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("t6_pulse_cnt", 32'(pulse_cnt), 0);
        check("t6_igbt", 32'(igbt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
